pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Central hazard controller for the five-stage MIPS pipeline. Each cycle it decides stall and bubble controls for the F, D and E pipeline registers, and selects forwarding sources for the decode-stage operands. It also sequences the multi-cycle HI/LO multiply/divide unit with a busy counter. It sits beside the pipeline registers and drives their `*_stall` and `*_bubble` inputs.

## Interface
Parameters:
- `MUL_LAT`, default 4: busy cycles for MULT/MULTU, minimum 1.
- `DIV_LAT`, default 32: busy cycles for DIV/DIVU, minimum 1.
- `CNT_W`, default 6: counter width; must satisfy 2^CNT_W > max(MUL_LAT, DIV_LAT).

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `resetn` in 1: synchronous, active-low reset.
- `D_op`, `D_func` in 6 each: instruction currently in decode.
- `d_srcA`, `d_srcB` in 5 each: decode source registers; `RNONE` means unused.
- `E_op`, `E_func` in 6 each: instruction in execute.
- `E_dstE`, `E_dstM` in 5 each: execute-stage destinations.
- `M_dstE`, `M_dstM` in 5 each: memory-stage destinations.
- `W_dstE`, `W_dstM` in 5 each: writeback-stage destinations.
- `e_redirect` in 1: branch or jump in E changes the PC this cycle.
- `F_stall`, `D_stall` out 1 each: hold the F and D registers.
- `D_bubble`, `E_bubble` out 1 each: load a NOP into the D and E registers.
- `fwdA_sel`, `fwdB_sel` out 3 each: operand source select.
- `md_start` out 1: launch the multiply/divide unit.
- `md_busy` out 1: multiply/divide unit is busy.
- `md_done` out 1: last busy cycle.

## Operation
- **Forwarding** (combinational). Evaluate per source X, in priority order; the first match wins:
  1. X = `RNONE` → 0 (register file).
  2. X == `E_dstE` → 1 (`e_valE`).
  3. X == `M_dstM` → 2 (`m_valM`).
  4. X == `M_dstE` → 3 (`M_valE`).
  5. X == `W_dstM` → 4 (`W_valM`).
  6. X == `W_dstE` → 5 (`W_valE`).
  7. Otherwise → 0.
  - Codes 6 and 7 are never driven.
- **Load-use**: `E_dstM` != `RNONE` and `E_dstM` equals `d_srcA` or `d_srcB`.
- **HI/LO hazard**: the D instruction is MFHI, MFLO, MTHI, MTLO, MULT, MULTU, DIV or DIVU, and (`md_busy` or `md_start`) is high.
- **Stall**: load-use or HI/LO hazard → `F_stall` = `D_stall` = `E_bubble` = 1, `D_bubble` = 0.
- **Redirect**: `e_redirect` → `D_bubble` = `E_bubble` = 1, `F_stall` = `D_stall` = 0.
  - Redirect overrides every stall condition in the same cycle.
- **Multiply/divide FSM**, two states:
  - IDLE → BUSY: when E holds a MULT/MULTU/DIV/DIVU and the FSM is IDLE, `md_start` = 1 combinationally. Next edge: counter ← LAT−1, state ← BUSY.
  - BUSY: `md_busy` = 1. Counter decrements each cycle. `md_done` = 1 when counter == 0; the next edge returns to IDLE.
  - `md_start` is never asserted while in BUSY.
  - `e_redirect` does not cancel an operation already started.
- **Reset**: while `resetn` = 0 at an edge, state ← IDLE and counter ← 0.
  - While `resetn` is low, outputs are forced: `D_bubble` = `E_bubble` = 1, `F_stall` = `D_stall` = `md_start` = 0, sel = 0.
  - Asserting reset mid-operation aborts the operation; `md_busy` is 0 after the edge.

## Timing
- Forwarding selects and stall/bubble outputs are combinational from the current-cycle inputs and FSM state; no added latency.
- `md_busy` rises the cycle after `md_start` and stays high exactly LAT cycles; `md_done` is high in the final one.
- A HI/LO-using instruction in D stalls from the `md_start` cycle through the `md_done` cycle, then advances on the following edge.
- Load-use costs exactly one bubble cycle.
- Back-to-back MULT: the second MULT holds in D for 1+LAT cycles.
- Reset values: state IDLE, counter 0, `md_busy` = `md_done` = 0.

## Structure
- Shared package `def.v` holds:
  - `RNONE`
  - opcode/func constants (SPECIAL, MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO)
  - `FWD_RF`, `FWD_EVALE`, `FWD_MVALM`, `FWD_MVALE`, `FWD_WVALM`, `FWD_WVALE`
- Sub-module `md_seq`: the IDLE/BUSY FSM and counter, with ports `clk`, `resetn`, `start`, `is_div`, `busy`, `done`.
- Forwarding is two instances of one combinational function.

## Test plan
- `d_srcA`=8, `E_dstE`=8, `M_dstE`=8 → `fwdA_sel`=1. With `E_dstE`=`RNONE` → 3. `d_srcA`=`RNONE` with all dst=8 → 0.
- LW to $9 in E, `d_srcB`=9 → exactly one cycle `F_stall`=`D_stall`=`E_bubble`=1; next cycle `fwdB_sel`=2.
- MULT in E, MFLO in D (`MUL_LAT`=4) → `md_start` 1 cycle, `md_busy` 4 cycles, `md_done` on the 4th; MFLO stalls 5 cycles, then advances.
- Load-use plus `e_redirect` in the same cycle → `D_bubble`=`E_bubble`=1, `F_stall`=0.
- DIV running (`DIV_LAT`=32), `resetn` low for 1 edge at busy cycle 10 → `md_busy`=0 next cycle; bubbles asserted during reset.
- MULT followed by DIV in consecutive instructions → DIV held in D until MULT `md_done`; DIV `md_start` fires only after that.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared constants, types and decode helpers for the pipeline hazard controller.
// Pure declarations; no latency.
// No flow control; consumed by combinational logic only.
package pipe_ctrl_pkg;

    // Register $0 is hardwired to zero, so it doubles as "no register".
    localparam logic [4:0] RNONE      = 5'd0;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] FN_MFHI    = 6'h10;
    localparam logic [5:0] FN_MTHI    = 6'h11;
    localparam logic [5:0] FN_MFLO    = 6'h12;
    localparam logic [5:0] FN_MTLO    = 6'h13;
    localparam logic [5:0] FN_MULT    = 6'h18;
    localparam logic [5:0] FN_MULTU   = 6'h19;
    localparam logic [5:0] FN_DIV     = 6'h1a;
    localparam logic [5:0] FN_DIVU    = 6'h1b;

    typedef enum logic [2:0] {
        FWD_RF    = 3'd0,
        FWD_EVALE = 3'd1,
        FWD_MVALM = 3'd2,
        FWD_MVALE = 3'd3,
        FWD_WVALM = 3'd4,
        FWD_WVALE = 3'd5
    } fwd_sel_t;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

    // Instruction launches the multiply/divide unit.
    function automatic logic is_muldiv(input logic [5:0] op, input logic [5:0] func);
        return (op == OP_SPECIAL) && (func inside {FN_MULT, FN_MULTU, FN_DIV, FN_DIVU});
    endfunction

    // Selects the divide latency rather than the multiply latency.
    function automatic logic is_div(input logic [5:0] op, input logic [5:0] func);
        return (op == OP_SPECIAL) && (func inside {FN_DIV, FN_DIVU});
    endfunction

    // Instruction reads or writes HI/LO and must wait for the unit to go idle.
    function automatic logic is_hilo(input logic [5:0] op, input logic [5:0] func);
        return (op == OP_SPECIAL) &&
               (func inside {FN_MFHI, FN_MTHI, FN_MFLO, FN_MTLO,
                             FN_MULT, FN_MULTU, FN_DIV, FN_DIVU});
    endfunction

    // Youngest producer wins; within M and W the memory result outranks the ALU result.
    function automatic fwd_sel_t fwd_select(
        input logic [4:0] src,
        input logic [4:0] e_dst_e,
        input logic [4:0] m_dst_m,
        input logic [4:0] m_dst_e,
        input logic [4:0] w_dst_m,
        input logic [4:0] w_dst_e
    );
        if (src == RNONE)        return FWD_RF;
        else if (src == e_dst_e) return FWD_EVALE;
        else if (src == m_dst_m) return FWD_MVALM;
        else if (src == m_dst_e) return FWD_MVALE;
        else if (src == w_dst_m) return FWD_WVALM;
        else if (src == w_dst_e) return FWD_WVALE;
        else                     return FWD_RF;
    endfunction

endpackage

// File: rtl/pipe_ctrl_md_seq.sv
// Multiply/divide busy sequencer: IDLE/BUSY FSM with a down-counter.
// busy rises the cycle after start and lasts exactly LAT cycles; done marks the last one.
// start is ignored while busy; synchronous reset aborts a running operation.
module md_seq #(
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 32,
    parameter int CNT_W   = 6
) (
    input  logic clk,
    input  logic resetn,
    input  logic start,
    input  logic is_div,
    output logic busy,
    output logic done
);
    import pipe_ctrl_pkg::*;

    // Counter holds "busy cycles remaining minus one", so it reaches zero on the final cycle.
    localparam logic [CNT_W-1:0] MUL_INIT = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_INIT = CNT_W'(DIV_LAT - 1);

    md_state_t        state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    // State and counter registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= MD_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state, counter load/decrement and status outputs.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            MD_IDLE: begin
                if (start) begin
                    state_nxt = MD_BUSY;
                    cnt_nxt   = is_div ? DIV_INIT : MUL_INIT;
                end
            end
            MD_BUSY: begin
                busy = 1'b1;
                if (cnt == '0) begin
                    done      = 1'b1;
                    state_nxt = MD_IDLE;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            default: state_nxt = MD_IDLE;
        endcase
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: forwarding selects, stall/bubble controls, mul/div sequencing.
// All controls are combinational from current inputs and sequencer state (zero latency).
// Load-use and HI/LO hazards stall F/D and bubble E; an E-stage redirect overrides any stall.
module pipe_ctrl #(
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 32,
    parameter int CNT_W   = 6    // 2**CNT_W must exceed both latencies
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [5:0] D_op,
    input  logic [5:0] D_func,
    input  logic [4:0] d_srcA,
    input  logic [4:0] d_srcB,
    input  logic [5:0] E_op,
    input  logic [5:0] E_func,
    input  logic [4:0] E_dstE,
    input  logic [4:0] E_dstM,
    input  logic [4:0] M_dstE,
    input  logic [4:0] M_dstM,
    input  logic [4:0] W_dstE,
    input  logic [4:0] W_dstM,
    input  logic       e_redirect,
    output logic       F_stall,
    output logic       D_stall,
    output logic       D_bubble,
    output logic       E_bubble,
    output logic [2:0] fwdA_sel,
    output logic [2:0] fwdB_sel,
    output logic       md_start,
    output logic       md_busy,
    output logic       md_done
);
    import pipe_ctrl_pkg::*;

    logic e_md;
    logic e_div;
    logic d_hilo;
    logic md_go;
    logic load_use;
    logic hilo_haz;

    assign e_md   = is_muldiv(E_op, E_func);
    assign e_div  = is_div(E_op, E_func);
    assign d_hilo = is_hilo(D_op, D_func);

    // Launch only from idle; a redirect does not suppress it, and reset does.
    assign md_go  = resetn && e_md && !md_busy;

    // The loaded value is not available until M, so a dependent D instruction waits one cycle.
    assign load_use = (E_dstM != RNONE) && ((E_dstM == d_srcA) || (E_dstM == d_srcB));

    // Counting the launch cycle keeps a HI/LO user from slipping past a MULT issuing right now.
    assign hilo_haz = d_hilo && (md_busy || md_go);

    md_seq #(
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT),
        .CNT_W   (CNT_W)
    ) u_md_seq (
        .clk    (clk),
        .resetn (resetn),
        .start  (md_go),
        .is_div (e_div),
        .busy   (md_busy),
        .done   (md_done)
    );

    // Pipeline-register controls and forwarding selects; reset beats redirect beats stall.
    always_comb begin
        F_stall  = 1'b0;
        D_stall  = 1'b0;
        D_bubble = 1'b0;
        E_bubble = 1'b0;
        md_start = md_go;
        fwdA_sel = fwd_select(d_srcA, E_dstE, M_dstM, M_dstE, W_dstM, W_dstE);
        fwdB_sel = fwd_select(d_srcB, E_dstE, M_dstM, M_dstE, W_dstM, W_dstE);
        if (!resetn) begin
            D_bubble = 1'b1;
            E_bubble = 1'b1;
            fwdA_sel = FWD_RF;
            fwdB_sel = FWD_RF;
        end else if (e_redirect) begin
            D_bubble = 1'b1;
            E_bubble = 1'b1;
        end else if (load_use || hilo_haz) begin
            F_stall  = 1'b1;
            D_stall  = 1'b1;
            E_bubble = 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed hazard scenarios plus random traffic.
// A remaining-cycles model of the mul/div unit and priority-list forwarding model are compared every cycle.
// Inputs change 1 time unit after the rising edge; outputs are compared on the falling edge.
module tb_pipe_ctrl;

    localparam logic [5:0] NOP_OP = 6'h00;
    localparam logic [5:0] NOP_FN = 6'h21;   // ADDU
    localparam logic [5:0] LW_OP  = 6'h23;
    localparam logic [5:0] SP     = 6'h00;
    localparam logic [5:0] MULT   = 6'h18;
    localparam logic [5:0] DIV    = 6'h1a;
    localparam logic [5:0] MFLO   = 6'h12;
    localparam int         MLAT   = 4;
    localparam int         DLAT   = 32;

    logic       clk = 1'b0;
    logic       resetn;
    logic [5:0] D_op, D_func, E_op, E_func;
    logic [4:0] d_srcA, d_srcB, E_dstE, E_dstM, M_dstE, M_dstM, W_dstE, W_dstM;
    logic       e_redirect;
    logic       F_stall, D_stall, D_bubble, E_bubble;
    logic [2:0] fwdA_sel, fwdB_sel;
    logic       md_start, md_busy, md_done;

    int n_pass = 0;
    int n_tot  = 0;
    bit en     = 1'b0;
    int rem    = 0;     // busy cycles still owed by the mul/div unit

    pipe_ctrl #(.MUL_LAT(MLAT), .DIV_LAT(DLAT), .CNT_W(6)) dut (
        .clk(clk), .resetn(resetn),
        .D_op(D_op), .D_func(D_func), .d_srcA(d_srcA), .d_srcB(d_srcB),
        .E_op(E_op), .E_func(E_func), .E_dstE(E_dstE), .E_dstM(E_dstM),
        .M_dstE(M_dstE), .M_dstM(M_dstM), .W_dstE(W_dstE), .W_dstM(W_dstM),
        .e_redirect(e_redirect),
        .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble), .E_bubble(E_bubble),
        .fwdA_sel(fwdA_sel), .fwdB_sel(fwdB_sel),
        .md_start(md_start), .md_busy(md_busy), .md_done(md_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act !== exp) $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        else n_pass++;
    endtask

    // ---------------- behavioural model ----------------
    function automatic bit m_md(input logic [5:0] op, input logic [5:0] fn);
        return op == 6'h00 && fn >= 6'h18 && fn <= 6'h1b;
    endfunction

    function automatic bit m_hilo(input logic [5:0] op, input logic [5:0] fn);
        return op == 6'h00 && ((fn >= 6'h10 && fn <= 6'h13) || m_md(op, fn));
    endfunction

    function automatic int m_fwd(input logic [4:0] x);
        logic [4:0] cand [5];
        cand = '{E_dstE, M_dstM, M_dstE, W_dstM, W_dstE};
        if (x == 5'd0) return 0;
        for (int i = 0; i < 5; i++) if (x == cand[i]) return i + 1;
        return 0;
    endfunction

    function automatic bit m_start();
        return resetn === 1'b1 && m_md(E_op, E_func) && rem == 0;
    endfunction

    // Model of the mul/div unit: counts down the cycles still owed.
    always @(posedge clk) begin
        if (resetn !== 1'b1)  rem = 0;
        else if (m_start())   rem = (E_func == 6'h1a || E_func == 6'h1b) ? DLAT : MLAT;
        else if (rem > 0)     rem = rem - 1;
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (en) begin
            bit lu, st, fs, db, eb;
            int fa, fb;
            lu = E_dstM != 5'd0 && (E_dstM == d_srcA || E_dstM == d_srcB);
            st = m_start();
            fa = m_fwd(d_srcA);
            fb = m_fwd(d_srcB);
            fs = 0; db = 0; eb = 0;
            if (!resetn) begin
                db = 1; eb = 1; fa = 0; fb = 0;
            end else if (e_redirect) begin
                db = 1; eb = 1;
            end else if (lu || (m_hilo(D_op, D_func) && (rem > 0 || st))) begin
                fs = 1; eb = 1;
            end
            chk("cyc_F_stall", F_stall, fs);
            chk("cyc_D_stall", D_stall, fs);
            chk("cyc_D_bubble", D_bubble, db);
            chk("cyc_E_bubble", E_bubble, eb);
            chk("cyc_fwdA", fwdA_sel, fa);
            chk("cyc_fwdB", fwdB_sel, fb);
            chk("cyc_md_start", md_start, st);
            chk("cyc_md_busy", md_busy, rem > 0);
            chk("cyc_md_done", md_done, rem == 1);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        D_op = NOP_OP; D_func = NOP_FN; E_op = NOP_OP; E_func = NOP_FN;
        d_srcA = 0; d_srcB = 0; E_dstE = 0; E_dstM = 0;
        M_dstE = 0; M_dstM = 0; W_dstE = 0; W_dstM = 0; e_redirect = 0;
    endtask

    // Advance a minimal D->E pipeline according to the controls just produced.
    task automatic adv();
        logic eb, ds;
        logic [5:0] dop, dfn;
        eb = E_bubble; ds = D_stall; dop = D_op; dfn = D_func;
        tick();
        if (eb) begin E_op = NOP_OP; E_func = NOP_FN; end
        else    begin E_op = dop;    E_func = dfn;    end
        if (!ds) begin D_op = NOP_OP; D_func = NOP_FN; end
    endtask

    initial begin
        int c_st, c_b, c_d, c_stall, done_at, held;
        bit div_started;

        // Reset: outputs forced even with a MULT sitting in E.
        clr();
        resetn = 0;
        E_op = SP; E_func = MULT; d_srcA = 8; E_dstE = 8;
        #3;
        chk("rst_D_bubble", D_bubble, 1);
        chk("rst_E_bubble", E_bubble, 1);
        chk("rst_F_stall", F_stall, 0);
        chk("rst_md_start", md_start, 0);
        chk("rst_fwdA", fwdA_sel, 0);
        tick();
        en = 1;
        #2;
        chk("rst_md_busy", md_busy, 0);
        chk("rst_md_done", md_done, 0);
        clr();
        tick();
        resetn = 1;

        // Forwarding priority.
        d_srcA = 8; E_dstE = 8; M_dstE = 8; #1;
        chk("fwd_E_over_M", fwdA_sel, 1);
        E_dstE = 0; #1;
        chk("fwd_MvalE", fwdA_sel, 3);
        d_srcA = 0; E_dstE = 8; M_dstM = 8; W_dstE = 8; W_dstM = 8; #1;
        chk("fwd_rnone", fwdA_sel, 0);
        clr(); d_srcB = 12; W_dstE = 12; #1;
        chk("fwd_WvalE", fwdB_sel, 5);
        W_dstM = 12; M_dstM = 12; #1;
        chk("fwd_MvalM", fwdB_sel, 2);
        tick();

        // Load-use: one stall cycle, then forward from m_valM.
        clr(); E_op = LW_OP; E_dstM = 9; d_srcA = 3; d_srcB = 9; #2;
        chk("lu_F_stall", F_stall, 1);
        chk("lu_D_stall", D_stall, 1);
        chk("lu_E_bubble", E_bubble, 1);
        chk("lu_D_bubble", D_bubble, 0);
        tick();
        E_op = NOP_OP; E_dstM = 0; M_dstM = 9; #2;
        chk("lu_after_stall", F_stall, 0);
        chk("lu_after_fwdB", fwdB_sel, 2);
        tick();

        // Redirect overrides load-use.
        clr(); E_op = LW_OP; E_dstM = 9; d_srcB = 9; e_redirect = 1; #2;
        chk("redir_D_bubble", D_bubble, 1);
        chk("redir_E_bubble", E_bubble, 1);
        chk("redir_F_stall", F_stall, 0);
        chk("redir_D_stall", D_stall, 0);
        tick();

        // MULT in E, MFLO in D.
        clr(); E_op = SP; E_func = MULT; D_op = SP; D_func = MFLO;
        c_st = 0; c_b = 0; c_d = 0; c_stall = 0; done_at = 0;
        for (int k = 0; k < 10; k++) begin
            #2;
            if (k == 0) chk("mul_first_busy", md_busy, 0);
            if (md_start) c_st++;
            if (md_busy) c_b++;
            if (md_done) begin c_d++; done_at = c_b; end
            if (D_stall) c_stall++;
            adv();
        end
        chk("mul_start_cycles", c_st, 1);
        chk("mul_busy_cycles", c_b, MLAT);
        chk("mul_done_cycles", c_d, 1);
        chk("mul_done_on_last", done_at, MLAT);
        chk("mflo_stall_cycles", c_stall, 1 + MLAT);

        // MULT followed by DIV: DIV waits in D, then launches from E.
        clr(); E_op = SP; E_func = MULT; D_op = SP; D_func = DIV;
        held = 0; div_started = 0;
        for (int k = 0; k < 12; k++) begin
            #2;
            if (D_op == SP && D_func == DIV && D_stall) held++;
            if (E_op == SP && E_func == DIV && !div_started) begin
                div_started = 1;
                chk("div_start_after_mul", md_start, 1);
                chk("div_start_idle", md_busy, 0);
            end
            adv();
        end
        chk("div_held_cycles", held, 1 + MLAT);
        chk("div_launched", div_started, 1);

        // DIV aborted by reset at busy cycle 10.
        clr(); resetn = 0; tick(); resetn = 1;
        E_op = SP; E_func = DIV; #2;
        chk("div_start", md_start, 1);
        tick();
        clr();
        for (int k = 1; k < 10; k++) tick();
        #2;
        chk("div_busy_c10", md_busy, 1);
        resetn = 0; #1;
        chk("div_rst_D_bubble", D_bubble, 1);
        chk("div_rst_E_bubble", E_bubble, 1);
        chk("div_rst_F_stall", F_stall, 0);
        tick();
        resetn = 1; #2;
        chk("div_abort_busy", md_busy, 0);
        tick();

        // Random traffic.
        for (int k = 0; k < 3000; k++) begin
            int r;
            resetn = ($urandom_range(0, 63) != 0);
            r = $urandom_range(0, 9);
            E_op = (r == 2) ? LW_OP : SP;
            E_func = (r < 2) ? 6'(6'h18 + $urandom_range(0, 3)) :
                     (r == 3) ? 6'(6'h10 + $urandom_range(0, 3)) : NOP_FN;
            r = $urandom_range(0, 9);
            D_op = (r == 2) ? LW_OP : SP;
            D_func = (r < 2) ? 6'(6'h18 + $urandom_range(0, 3)) :
                     (r < 5) ? 6'(6'h10 + $urandom_range(0, 3)) : NOP_FN;
            d_srcA = 5'($urandom_range(0, 7)); d_srcB = 5'($urandom_range(0, 7));
            E_dstE = 5'($urandom_range(0, 7)); E_dstM = 5'($urandom_range(0, 7));
            M_dstE = 5'($urandom_range(0, 7)); M_dstM = 5'($urandom_range(0, 7));
            W_dstE = 5'($urandom_range(0, 7)); W_dstM = 5'($urandom_range(0, 7));
            e_redirect = ($urandom_range(0, 7) == 0);
            tick();
        end

        #5;
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
